// File: rtl/uart_echo_buffer_pkg.sv
// Shared constants for the UART echo buffer: mode encodings and the
// substitution character used for errored words.
package uart_echo_pkg;

  localparam logic [1:0] MODE_RAW   = 2'b00;
  localparam logic [1:0] MODE_BUF   = 2'b01;
  localparam logic [1:0] MODE_SUBST = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [7:0] SUBST_CHAR = 8'h3F;

endpackage

// File: rtl/uart_echo_buffer_sfifo.sv
// Synchronous FIFO, 2**LGFLEN words, with flush. Exposes the post-edge head
// word and fill so the consumer can register its strobe/data without a bubble.
module echo_sfifo #(
  parameter int DW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DW-1:0]     push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [LGFLEN:0]   fill,
  output logic [LGFLEN:0]   fill_next,
  output logic [DW-1:0]     head_next
);

  localparam logic [LGFLEN:0] DEPTH = {1'b1, {LGFLEN{1'b0}}};

  logic [DW-1:0]     mem [0:(1<<LGFLEN)-1];
  logic [LGFLEN-1:0] wr_ptr;
  logic [LGFLEN-1:0] rd_ptr;
  logic [LGFLEN-1:0] rd_next;
  logic [LGFLEN:0]   remain;
  logic              do_push;
  logic              do_pop;

  assign full    = (fill == DEPTH);
  assign empty   = (fill == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  assign rd_next   = rd_ptr + LGFLEN'(do_pop);
  assign remain    = fill - (LGFLEN+1)'(do_pop);
  assign fill_next = flush ? '0
                   : fill + (LGFLEN+1)'(do_push) - (LGFLEN+1)'(do_pop);
  // Head after the edge: the incoming word if nothing else remains queued.
  assign head_next = (remain == '0) ? push_data : mem[rd_next];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LGFLEN'(1);
      rd_ptr <= rd_next;
      fill   <= fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Echo engine between rxuart and txuart: registered raw-wire echo or decoded
// echo through a drift-absorbing FIFO, with error substitution, break and hold.
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int DW     = 8,
  parameter int LGFLEN = 4,
  parameter int CNTW   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_mode,
  input  logic              i_uart_rx,
  input  logic              i_rx_stb,
  input  logic [DW-1:0]     i_rx_data,
  input  logic              i_rx_break,
  input  logic              i_rx_perr,
  input  logic              i_rx_ferr,
  output logic              o_tx_stb,
  output logic [DW-1:0]     o_tx_data,
  output logic              o_tx_break,
  input  logic              i_tx_busy,
  input  logic              i_tx_serial,
  output logic              o_uart_tx,
  output logic [LGFLEN:0]   o_fill,
  output logic [CNTW-1:0]   o_overflow
);

  logic            mode_raw;
  logic            push;
  logic            pop;
  logic [DW-1:0]   push_word;
  logic            full;
  logic            empty;
  logic [LGFLEN:0] fill_next;
  logic [DW-1:0]   head_next;
  logic            stb_next;

  assign mode_raw  = (i_mode == MODE_RAW);
  assign push      = i_rx_stb && !mode_raw;
  assign push_word = (i_mode == MODE_SUBST && (i_rx_perr || i_rx_ferr))
                   ? DW'(SUBST_CHAR) : i_rx_data;
  assign pop       = o_tx_stb && !i_tx_busy && !empty;
  assign stb_next  = !mode_raw && (i_mode != MODE_HOLD) && !i_rx_break
                   && (fill_next != '0);

  echo_sfifo #(
    .DW     (DW),
    .LGFLEN (LGFLEN)
  ) u_fifo (
    .clk       (i_clk),
    .reset_n   (i_reset_n),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .flush     (mode_raw),
    .full      (full),
    .empty     (empty),
    .fill      (o_fill),
    .fill_next (fill_next),
    .head_next (head_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_uart_tx  <= 1'b1;
      o_tx_stb   <= 1'b0;
      o_tx_data  <= '0;
      o_tx_break <= 1'b0;
    end else begin
      o_uart_tx  <= mode_raw ? i_uart_rx : i_tx_serial;
      o_tx_stb   <= stb_next;
      o_tx_break <= i_rx_break && !mode_raw;
      // Holding data while the queue drains keeps o_tx_data stable under stb.
      if (fill_next != '0) o_tx_data <= head_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_overflow <= '0;
    end else if (push && full && !pop && (o_overflow != '1)) begin
      o_overflow <= o_overflow + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer with immediate-assertion checks.
module tb_uart_echo_buffer;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [1:0]  i_mode;
  logic        i_uart_rx;
  logic        i_rx_stb;
  logic [7:0]  i_rx_data;
  logic        i_rx_break;
  logic        i_rx_perr;
  logic        i_rx_ferr;
  logic        o_tx_stb;
  logic [7:0]  o_tx_data;
  logic        o_tx_break;
  logic        i_tx_busy;
  logic        i_tx_serial;
  logic        o_uart_tx;
  logic [4:0]  o_fill;
  logic [15:0] o_overflow;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 i_clk = ~i_clk;

  uart_echo_buffer #(.DW(8), .LGFLEN(4), .CNTW(16)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_mode      (i_mode),
    .i_uart_rx   (i_uart_rx),
    .i_rx_stb    (i_rx_stb),
    .i_rx_data   (i_rx_data),
    .i_rx_break  (i_rx_break),
    .i_rx_perr   (i_rx_perr),
    .i_rx_ferr   (i_rx_ferr),
    .o_tx_stb    (o_tx_stb),
    .o_tx_data   (o_tx_data),
    .o_tx_break  (o_tx_break),
    .i_tx_busy   (i_tx_busy),
    .i_tx_serial (i_tx_serial),
    .o_uart_tx   (o_uart_tx),
    .o_fill      (o_fill),
    .o_overflow  (o_overflow)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [7:0] d, input logic perr, input logic ferr);
    i_rx_stb  = 1'b1;
    i_rx_data = d;
    i_rx_perr = perr;
    i_rx_ferr = ferr;
    tick();
    i_rx_stb  = 1'b0;
    i_rx_perr = 1'b0;
    i_rx_ferr = 1'b0;
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_mode      = 2'b00;
    i_uart_rx   = 1'b1;
    i_rx_stb    = 1'b0;
    i_rx_data   = 8'h00;
    i_rx_break  = 1'b0;
    i_rx_perr   = 1'b0;
    i_rx_ferr   = 1'b0;
    i_tx_busy   = 1'b0;
    i_tx_serial = 1'b1;
    tick();
    tick();
    check("rst_uart_tx", 32'(o_uart_tx), 32'h1);
    check("rst_tx_stb", 32'(o_tx_stb), 32'h0);
    check("rst_tx_data", 32'(o_tx_data), 32'h0);
    check("rst_tx_break", 32'(o_tx_break), 32'h0);
    check("rst_fill", 32'(o_fill), 32'h0);
    check("rst_overflow", 32'(o_overflow), 32'h0);
    i_reset_n = 1'b1;
    tick();

    // 1: raw echo, registered one clock
    i_tx_serial = 1'b0;
    i_uart_rx = 1'b1;
    tick();
    check("raw_1", 32'(o_uart_tx), 32'h1);
    i_uart_rx = 1'b0;
    #1;
    check("raw_0_before_edge", 32'(o_uart_tx), 32'h1);
    tick();
    check("raw_0", 32'(o_uart_tx), 32'h0);
    i_uart_rx = 1'b1;
    push_one(8'h41, 1'b0, 1'b0);
    check("raw_1_again", 32'(o_uart_tx), 32'h1);
    check("raw_no_stb", 32'(o_tx_stb), 32'h0);
    check("raw_no_fill", 32'(o_fill), 32'h0);
    i_tx_serial = 1'b1;

    // 2: buffered single word, immediate accept
    i_mode = 2'b01;
    tick();
    push_one(8'h41, 1'b0, 1'b0);
    check("buf_stb", 32'(o_tx_stb), 32'h1);
    check("buf_data", 32'(o_tx_data), 32'h41);
    check("buf_fill1", 32'(o_fill), 32'h1);
    tick();
    check("buf_stb_off", 32'(o_tx_stb), 32'h0);
    check("buf_fill0", 32'(o_fill), 32'h0);
    i_tx_serial = 1'b0;
    tick();
    check("buf_uart_tx_src", 32'(o_uart_tx), 32'h0);
    i_tx_serial = 1'b1;

    // 3: overflow with tx busy, then push+pop while full
    i_tx_busy = 1'b1;
    for (int i = 0; i < 18; i++) push_one(8'h10 + 8'(i), 1'b0, 1'b0);
    check("full_fill", 32'(o_fill), 32'd16);
    check("full_overflow", 32'(o_overflow), 32'd2);
    check("full_head", 32'(o_tx_data), 32'h10);
    i_tx_busy = 1'b0;
    push_one(8'hA0, 1'b0, 1'b0);
    check("pushpop_fill", 32'(o_fill), 32'd16);
    check("pushpop_overflow", 32'(o_overflow), 32'd2);
    for (int k = 0; k < 16; k++) begin
      check("drain_stb", 32'(o_tx_stb), 32'h1);
      check("drain_data", 32'(o_tx_data), (k < 15) ? 32'h11 + 32'(k) : 32'hA0);
      tick();
    end
    check("drain_empty", 32'(o_fill), 32'h0);
    check("drain_stb_off", 32'(o_tx_stb), 32'h0);

    // 4: error substitution
    i_mode = 2'b10;
    tick();
    push_one(8'h55, 1'b0, 1'b1);
    check("subst_ferr", 32'(o_tx_data), 32'h3F);
    tick();
    push_one(8'h55, 1'b0, 1'b0);
    check("subst_clean", 32'(o_tx_data), 32'h55);
    tick();
    push_one(8'h55, 1'b1, 1'b0);
    check("subst_perr", 32'(o_tx_data), 32'h3F);
    tick();
    i_mode = 2'b01;
    push_one(8'h55, 1'b0, 1'b1);
    check("nosubst_mode01", 32'(o_tx_data), 32'h55);
    tick();
    check("subst_empty", 32'(o_fill), 32'h0);

    // 5: hold, release in order, flush on entry to raw
    i_mode = 2'b11;
    push_one(8'h61, 1'b0, 1'b0);
    push_one(8'h62, 1'b0, 1'b0);
    push_one(8'h63, 1'b0, 1'b0);
    check("hold_stb", 32'(o_tx_stb), 32'h0);
    check("hold_fill", 32'(o_fill), 32'd3);
    i_mode = 2'b01;
    tick();
    check("rel_stb", 32'(o_tx_stb), 32'h1);
    check("rel_d0", 32'(o_tx_data), 32'h61);
    tick();
    check("rel_d1", 32'(o_tx_data), 32'h62);
    tick();
    check("rel_d2", 32'(o_tx_data), 32'h63);
    tick();
    check("rel_done_stb", 32'(o_tx_stb), 32'h0);
    check("rel_done_fill", 32'(o_fill), 32'h0);
    i_mode = 2'b11;
    push_one(8'h71, 1'b0, 1'b0);
    push_one(8'h72, 1'b0, 1'b0);
    check("preflush_fill", 32'(o_fill), 32'd2);
    i_mode = 2'b00;
    tick();
    check("flush_fill", 32'(o_fill), 32'h0);
    check("flush_stb", 32'(o_tx_stb), 32'h0);
    check("flush_overflow_kept", 32'(o_overflow), 32'd2);

    // 6: break holds pops, then drain, then reset mid-drain
    i_mode = 2'b11;
    push_one(8'h81, 1'b0, 1'b0);
    push_one(8'h82, 1'b0, 1'b0);
    i_mode = 2'b01;
    i_rx_break = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("brk_tx_break", 32'(o_tx_break), 32'h1);
      check("brk_stb", 32'(o_tx_stb), 32'h0);
      check("brk_fill", 32'(o_fill), 32'd2);
    end
    i_rx_break = 1'b0;
    tick();
    check("post_brk_break", 32'(o_tx_break), 32'h0);
    check("post_brk_stb", 32'(o_tx_stb), 32'h1);
    check("post_brk_d0", 32'(o_tx_data), 32'h81);
    i_tx_serial = 1'b0;
    tick();
    check("post_brk_d1", 32'(o_tx_data), 32'h82);
    check("post_brk_fill", 32'(o_fill), 32'd1);
    check("post_brk_uart_tx", 32'(o_uart_tx), 32'h0);
    i_reset_n = 1'b0;
    tick();
    check("rst2_uart_tx", 32'(o_uart_tx), 32'h1);
    check("rst2_tx_stb", 32'(o_tx_stb), 32'h0);
    check("rst2_tx_data", 32'(o_tx_data), 32'h0);
    check("rst2_tx_break", 32'(o_tx_break), 32'h0);
    check("rst2_fill", 32'(o_fill), 32'h0);
    check("rst2_overflow", 32'(o_overflow), 32'h0);
    i_reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
